// File: rtl/avalon_particle_fetch_master_if.sv
// avalon_particle_fetch_master_if: Avalon-MM read channel plus the particle valid/ready stream.
interface avalon_particle_fetch_master_if #(
    parameter int ADDR_W  = 32,
    parameter int FIELD_W = 10,
    parameter int CNT_W   = 8
);
    logic [ADDR_W-1:0]  AVM_ADDRESS;
    logic               AVM_READ;
    logic [3:0]         AVM_BYTEENABLE;
    logic [31:0]        AVM_READDATA;
    logic               AVM_WAITREQUEST;
    logic               P_VALID;
    logic               P_READY;
    logic [CNT_W-1:0]   P_INDEX;
    logic [FIELD_W-1:0] P_RADIUS;
    logic [FIELD_W-1:0] P_X;
    logic [FIELD_W-1:0] P_Y;
    logic [FIELD_W-1:0] P_Z;

    modport master (
        output AVM_ADDRESS, AVM_READ, AVM_BYTEENABLE,
        input  AVM_READDATA, AVM_WAITREQUEST,
        output P_VALID, P_INDEX, P_RADIUS, P_X, P_Y, P_Z,
        input  P_READY
    );

    modport slave (
        input  AVM_ADDRESS, AVM_READ, AVM_BYTEENABLE,
        output AVM_READDATA, AVM_WAITREQUEST,
        input  P_VALID, P_INDEX, P_RADIUS, P_X, P_Y, P_Z,
        output P_READY
    );
endinterface

// File: rtl/avalon_particle_fetch_master.sv
// avalon_particle_fetch_master: reads 4-word particle records over Avalon-MM and streams them to the renderer.
module avalon_particle_fetch_master #(
    parameter int ADDR_W  = 32,
    parameter int FIELD_W = 10,
    parameter int CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [CNT_W-1:0]  COUNT,
    output logic              BUSY,
    output logic              DONE,
    avalon_particle_fetch_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, PRESENT, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        idx_q, idx_d, count_q, count_d;
    logic [1:0]              word_q, word_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [3:0][FIELD_W-1:0] field_q, field_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            word_q  <= '0;
            base_q  <= '0;
            field_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            word_q  <= word_d;
            base_q  <= base_d;
            field_q <= field_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        word_d  = word_q;
        base_d  = base_q;
        field_d = field_q;
        case (state_q)
            IDLE: if (START) begin
                base_d  = BASE_ADDR;
                count_d = COUNT;
                idx_d   = '0;
                word_d  = '0;
                state_d = (COUNT == '0) ? FINISH : READ;
            end
            READ: if (!bus.AVM_WAITREQUEST) begin
                field_d[word_q] = bus.AVM_READDATA[FIELD_W-1:0];
                word_d          = word_q + 2'd1;
                state_d         = (word_q == 2'd3) ? PRESENT : READ;
            end
            PRESENT: if (bus.P_READY) begin
                if (idx_q == count_q - CNT_W'(1)) state_d = FINISH;
                else begin
                    idx_d   = idx_q + CNT_W'(1);
                    word_d  = '0;
                    state_d = READ;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Record layout is 16 bytes per particle, 4 bytes per word; the sum wraps at 2^ADDR_W.
    assign bus.AVM_READ       = (state_q == READ);
    assign bus.AVM_ADDRESS    = bus.AVM_READ ? base_q + ADDR_W'({idx_q, word_q, 2'b00}) : '0;
    assign bus.AVM_BYTEENABLE = 4'b1111;
    assign bus.P_VALID        = (state_q == PRESENT);
    assign bus.P_INDEX        = idx_q;
    assign bus.P_RADIUS       = field_q[0];
    assign bus.P_X            = field_q[1];
    assign bus.P_Y            = field_q[2];
    assign bus.P_Z            = field_q[3];
    assign BUSY               = (state_q != IDLE);
    assign DONE               = (state_q == FINISH);
endmodule

// File: tb/tb_avalon_particle_fetch_master.sv
// tb_avalon_particle_fetch_master: directed checks of the particle fetch master against a small word memory.
module tb_avalon_particle_fetch_master;
    logic        CLK = 0;
    logic        RESET = 1;
    logic        START = 0;
    logic [31:0] BASE_ADDR = 0;
    logic [7:0]  COUNT = 0;
    logic        BUSY, DONE;
    logic [31:0] mem [16];
    logic        ovr = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    avalon_particle_fetch_master_if #(.ADDR_W(32), .FIELD_W(10), .CNT_W(8)) bus ();

    avalon_particle_fetch_master #(.ADDR_W(32), .FIELD_W(10), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR),
        .COUNT(COUNT), .BUSY(BUSY), .DONE(DONE), .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Word memory indexed by address bits [5:2]; ovr injects garbage during stalls.
    assign bus.AVM_READDATA = ovr ? 32'h0000_03AA : mem[bus.AVM_ADDRESS[5:2]];

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_read(input string tag, input logic [31:0] addr);
        chk({tag, "_read"}, {31'd0, bus.AVM_READ}, 32'd1);
        chk({tag, "_addr"}, bus.AVM_ADDRESS, addr);
    endtask

    task automatic chk_rec(input string tag, input logic [7:0] idx, input logic [9:0] r,
                           input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
        chk({tag, "_valid"}, {31'd0, bus.P_VALID}, 32'd1);
        chk({tag, "_read0"}, {31'd0, bus.AVM_READ}, 32'd0);
        chk({tag, "_idx"}, {24'd0, bus.P_INDEX}, {24'd0, idx});
        chk({tag, "_r"}, {22'd0, bus.P_RADIUS}, {22'd0, r});
        chk({tag, "_x"}, {22'd0, bus.P_X}, {22'd0, x});
        chk({tag, "_y"}, {22'd0, bus.P_Y}, {22'd0, y});
        chk({tag, "_z"}, {22'd0, bus.P_Z}, {22'd0, z});
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, {31'd0, DONE}, 32'd1);
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
        chk({tag, "_pvalid"}, {31'd0, bus.P_VALID}, 32'd0);
        tick();
        chk({tag, "_done_off"}, {31'd0, DONE}, 32'd0);
        chk({tag, "_idle"}, {31'd0, BUSY}, 32'd0);
    endtask

    task automatic go(input logic [31:0] base, input logic [7:0] cnt);
        BASE_ADDR = base;
        COUNT     = cnt;
        START     = 1;
        tick();
        START     = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0] = 5;  mem[1] = 100; mem[2] = 200; mem[3] = 300;
        mem[4] = 11; mem[5] = 21;  mem[6] = 31;  mem[7] = 41;
        mem[8] = 12; mem[9] = 22;  mem[10] = 32; mem[11] = 42;
        mem[14] = 32'hFFFF_F3FF;
        mem[15] = 32'h0000_0ABC;
        bus.AVM_WAITREQUEST = 0;
        bus.P_READY = 1;
        @(negedge CLK);
        tick();
        tick();
        chk("rst_read", {31'd0, bus.AVM_READ}, 32'd0);
        chk("rst_addr", bus.AVM_ADDRESS, 32'd0);
        chk("rst_be", {28'd0, bus.AVM_BYTEENABLE}, 32'hF);
        chk("rst_pvalid", {31'd0, bus.P_VALID}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_idx", {24'd0, bus.P_INDEX}, 32'd0);
        chk("rst_r", {22'd0, bus.P_RADIUS}, 32'd0);
        RESET = 0;
        tick();
        chk("idle_busy", {31'd0, BUSY}, 32'd0);

        // 1: single particle, zero-wait
        go(32'h1000, 1);
        chk_read("t1_w0", 32'h1000);
        chk("t1_busy", {31'd0, BUSY}, 32'd1);
        tick(); chk_read("t1_w1", 32'h1004);
        tick(); chk_read("t1_w2", 32'h1008);
        tick(); chk_read("t1_w3", 32'h100C);
        tick(); chk_rec("t1_rec", 0, 5, 100, 200, 300);
        tick(); chk_done("t1");

        // 2: waitrequest stalls word 1 for three cycles
        go(32'h1000, 1);
        chk_read("t2_w0", 32'h1000);
        tick();
        bus.AVM_WAITREQUEST = 1;
        ovr = 1;
        for (int i = 0; i < 3; i++) begin
            chk_read("t2_stall", 32'h1004);
            tick();
        end
        bus.AVM_WAITREQUEST = 0;
        ovr = 0;
        chk_read("t2_w1", 32'h1004);
        tick(); chk_read("t2_w2", 32'h1008);
        tick(); chk_read("t2_w3", 32'h100C);
        tick(); chk_rec("t2_rec", 0, 5, 100, 200, 300);
        tick(); chk_done("t2");

        // 3: three particles, renderer stalls particle 1
        go(32'h1000, 3);
        chk_read("t3_p0w0", 32'h1000);
        tick(); tick(); tick();
        tick(); chk_rec("t3_rec0", 0, 5, 100, 200, 300);
        tick(); chk_read("t3_p1w0", 32'h1010);
        bus.P_READY = 0;
        tick(); chk_read("t3_p1w1", 32'h1014);
        tick(); tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_rec("t3_hold", 1, 11, 21, 31, 41);
            chk("t3_hold_busy", {31'd0, BUSY}, 32'd1);
            tick();
        end
        bus.P_READY = 1;
        chk_rec("t3_rec1", 1, 11, 21, 31, 41);
        tick(); chk_read("t3_p2w0", 32'h1020);
        tick(); chk_read("t3_p2w1", 32'h1024);
        tick(); chk_read("t3_p2w2", 32'h1028);
        tick(); chk_read("t3_p2w3", 32'h102C);
        tick(); chk_rec("t3_rec2", 2, 12, 22, 32, 42);
        tick(); chk_done("t3");

        // 4: empty pass
        go(32'h1000, 0);
        chk("t4_read", {31'd0, bus.AVM_READ}, 32'd0);
        chk_done("t4");
        chk("t4_read_after", {31'd0, bus.AVM_READ}, 32'd0);

        // 5a: START during READ is ignored
        go(32'h1000, 1);
        tick();
        BASE_ADDR = 32'h2000;
        COUNT = 2;
        START = 1;
        chk_read("t5_w1", 32'h1004);
        tick();
        START = 0;
        chk_read("t5_w2", 32'h1008);
        tick(); chk_read("t5_w3", 32'h100C);
        tick(); chk_rec("t5_rec", 0, 5, 100, 200, 300);
        tick(); chk_done("t5");
        chk("t5_no_restart", {31'd0, bus.AVM_READ}, 32'd0);

        // 5b: RESET mid-read
        go(32'h1000, 1);
        tick();
        RESET = 1;
        tick();
        RESET = 0;
        chk("t5r_read", {31'd0, bus.AVM_READ}, 32'd0);
        chk("t5r_busy", {31'd0, BUSY}, 32'd0);
        chk("t5r_done", {31'd0, DONE}, 32'd0);
        chk("t5r_pvalid", {31'd0, bus.P_VALID}, 32'd0);
        tick();
        chk("t5r_done2", {31'd0, DONE}, 32'd0);
        chk("t5r_busy2", {31'd0, BUSY}, 32'd0);

        // 6: field truncation and address wrap
        go(32'hFFFF_FFF8, 1);
        chk_read("t6_w0", 32'hFFFF_FFF8);
        tick(); chk_read("t6_w1", 32'hFFFF_FFFC);
        tick(); chk_read("t6_w2", 32'h0000_0000);
        tick(); chk_read("t6_w3", 32'h0000_0004);
        tick(); chk_rec("t6_rec", 0, 10'h3FF, 10'h2BC, 5, 100);
        tick(); chk_done("t6");
        chk("t6_hold_r", {22'd0, bus.P_RADIUS}, 32'h3FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
